// File: rtl/neo_lspc_pkg.sv
// rtl/neo_lspc_pkg.sv - LSPC timer register bit positions, widths and mode decode
package neo_lspc_pkg;

    localparam int          CNT_W_DEF    = 32;
    localparam logic [31:0] RST_LOAD_DEF = 32'hFFFF_FFFF;

    localparam int MODE_TIMER_EN = 4;
    localparam int MODE_RLD_WR   = 5;
    localparam int MODE_RLD_VBL  = 6;
    localparam int MODE_RLD_ZERO = 7;

    localparam int ACK_IRQ3  = 0;
    localparam int ACK_TIMER = 1;
    localparam int ACK_VBL   = 2;
    localparam int ACK_W     = 3;

    typedef struct packed {
        logic rld_zero;
        logic rld_vbl;
        logic rld_wr;
        logic timer_en;
    } lspc_mode_t;

    function automatic lspc_mode_t mode_from_data(input logic [15:0] d);
        lspc_mode_t m;
        m.rld_zero = d[MODE_RLD_ZERO];
        m.rld_vbl  = d[MODE_RLD_VBL];
        m.rld_wr   = d[MODE_RLD_WR];
        m.timer_en = d[MODE_TIMER_EN];
        return m;
    endfunction

endpackage

// File: rtl/lspc_timer_counter.sv
// rtl/lspc_timer_counter.sv - pixel-rate down-counter with prioritised load and zero detect
module lspc_timer_counter
    import neo_lspc_pkg::*;
#(
    parameter int             CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_LOAD = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_tick,
    input  logic             i_rld_zero,
    input  logic [CNT_W-1:0] i_reload,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    assign o_zero = (r_count == '0);

    // CPU/vblank loads win over pixel ticks; without auto-reload zero wraps to all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= RST_LOAD;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick) begin
            if (o_zero && i_rld_zero) begin
                r_count <= i_reload;
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lspc_timer_ctrl.sv
// rtl/lspc_timer_ctrl.sv - LSPC raster timer: mode/reload registers, timer IRQ and IRQ ack strobes
module lspc_timer_ctrl
    import neo_lspc_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_LOAD = RST_LOAD_DEF[CNT_W-1:0]
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en_pix,
    input  logic             i_vbl_start,
    input  logic             i_wr_mode,
    input  logic             i_wr_timer_hi,
    input  logic             i_wr_timer_lo,
    input  logic             i_wr_irqack,
    input  logic [15:0]      i_wr_data,
    output logic             o_timer_irq,
    output logic             o_timer_irq_en,
    output logic             o_vbl_irq_en,
    output logic             o_wr_ack,
    output logic [ACK_W-1:0] o_ack_bits
);

    lspc_mode_t       r_mode;
    logic [CNT_W-1:0] r_reload;
    logic             r_timer_irq;
    logic             r_wr_ack;
    logic [ACK_W-1:0] r_ack_bits;

    logic [CNT_W-1:0] w_reload_next;
    logic             w_load;
    logic             w_zero;
    logic             w_expire;

    // A load in the same cycle as a reload write must see the freshly written halves
    always_comb begin
        w_reload_next = r_reload;
        if (i_wr_timer_hi) w_reload_next[CNT_W-1:16] = i_wr_data[CNT_W-17:0];
        if (i_wr_timer_lo) w_reload_next[15:0]       = i_wr_data;
    end

    assign w_load   = (i_wr_timer_lo & r_mode.rld_wr) | (i_vbl_start & r_mode.rld_vbl);
    assign w_expire = i_clk_en_pix & w_zero & r_mode.timer_en;

    lspc_timer_counter #(
        .CNT_W    (CNT_W),
        .RST_LOAD (RST_LOAD)
    ) u_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_reload_next),
        .i_tick     (i_clk_en_pix),
        .i_rld_zero (r_mode.rld_zero),
        .i_reload   (r_reload),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= '0;
            r_reload    <= RST_LOAD;
            r_timer_irq <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_ack_bits  <= '0;
        end else begin
            if (i_wr_mode) r_mode <= mode_from_data(i_wr_data);
            r_reload    <= w_reload_next;
            r_timer_irq <= w_expire;
            r_wr_ack    <= i_wr_irqack;
            if (i_wr_irqack) begin
                r_ack_bits <= {i_wr_data[ACK_VBL], i_wr_data[ACK_TIMER], i_wr_data[ACK_IRQ3]};
            end
        end
    end

    assign o_timer_irq    = r_timer_irq;
    assign o_timer_irq_en = r_mode.timer_en;
    assign o_vbl_irq_en   = 1'b1;
    assign o_wr_ack       = r_wr_ack;
    assign o_ack_bits     = r_ack_bits;

endmodule
